// File: rtl/frec_pkg.sv
// Shared types and widths for the frequency generator: FSM state encoding
// and the width of the phase accumulator and window cycle counter.
package frec_pkg;

    localparam int unsigned ACC_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/acumulador_fase.sv
// Phase accumulator: adds step each cycle and strobes toggle on wrap past RESOL,
// spreading toggles evenly across the window.
module acumulador_fase
    import frec_pkg::*;
#(
    parameter int unsigned RESOL = 1000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [ACC_WIDTH-1:0] step,
    output logic                 toggle
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;

    // acc < RESOL and step <= RESOL, so sum < 2*RESOL never overflows.
    always_comb begin
        sum    = acc + step;
        toggle = (sum >= ACC_WIDTH'(RESOL));
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            acc <= '0;
        end else if (toggle) begin
            acc <= sum - ACC_WIDTH'(RESOL);
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/generador_frec.sv
// Emits N evenly spread rising edges on clock_u within a window of RESOL cycles,
// with clamping of N to RESOL/2, abort on enable low, and lock on completion.
module generador_frec
    import frec_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 32,
    parameter int unsigned RESOL    = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [IN_WIDTH-1:0] in,
    output logic                clock_u,
    output logic                lock,
    output logic                sat,
    output logic [IN_WIDTH-1:0] out
);

    localparam int unsigned          EXT_W = (IN_WIDTH > ACC_WIDTH) ? IN_WIDTH : ACC_WIDTH;
    localparam logic [ACC_WIDTH-1:0] HALF  = ACC_WIDTH'(RESOL / 2);
    localparam logic [ACC_WIDTH-1:0] LAST  = ACC_WIDTH'(RESOL - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] n_lat;
    logic [ACC_WIDTH-1:0] cnt;
    logic [EXT_W-1:0]     in_ext;
    logic                 sat_next;
    logic [ACC_WIDTH-1:0] n_next;
    logic [ACC_WIDTH-1:0] step;
    logic                 clear;
    logic                 toggle;

    always_comb begin
        in_ext   = EXT_W'(in);
        sat_next = (in_ext > EXT_W'(HALF));
        n_next   = sat_next ? HALF : in_ext[ACC_WIDTH-1:0];
        // Accumulator only advances in RUN; a zero step freezes it elsewhere.
        step     = (state == RUN) ? {n_lat[ACC_WIDTH-2:0], 1'b0} : '0;
        clear    = (state == IDLE);
    end

    acumulador_fase #(
        .RESOL(RESOL)
    ) u_acumulador_fase (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (clear),
        .step   (step),
        .toggle (toggle)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            clock_u <= 1'b0;
            lock    <= 1'b0;
            sat     <= 1'b0;
            out     <= '0;
            cnt     <= '0;
            n_lat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        n_lat <= n_next;
                        sat   <= sat_next;
                        out   <= '0;
                        cnt   <= '0;
                        lock  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        clock_u <= 1'b0;
                    end else begin
                        if (toggle) begin
                            clock_u <= ~clock_u;
                            if (!clock_u) begin
                                out <= out + IN_WIDTH'(1);
                            end
                        end
                        cnt <= cnt + ACC_WIDTH'(1);
                        if (cnt == LAST) begin
                            state <= DONE;
                            lock  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    clock_u <= 1'b0;
                    if (!enable) begin
                        state <= IDLE;
                        lock  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clock_u <= 1'b0;
                    lock    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_frec.sv
// Self-checking bench for generador_frec at RESOL=1000: table-driven windows
// scored through an expectation queue, plus abort and reset sequences.
module tb_generador_frec;

    localparam int unsigned RESOL = 1000;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [31:0] in;
    logic        clock_u;
    logic        lock;
    logic        sat;
    logic [31:0] out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [31:0] n;
        logic [31:0] exp_out;
        logic        exp_sat;
        int unsigned exp_first;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];

    generador_frec #(
        .IN_WIDTH(32),
        .RESOL   (RESOL)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (enable),
        .in     (in),
        .clock_u(clock_u),
        .lock   (lock),
        .sat    (sat),
        .out    (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_window(input vec_t v);
        int unsigned cycles  = 0;
        int unsigned rises   = 0;
        int unsigned toggles = 0;
        int unsigned first   = 0;
        logic        prev;
        logic        hold_ok;
        vec_t        e;
        sb.push_back(v);
        in     = v.n;
        enable = 1'b1;
        tick();
        prev = clock_u;
        in   = $urandom;
        while (!lock && cycles < RESOL + 20) begin
            tick();
            cycles++;
            in = $urandom;
            if (clock_u != prev) toggles++;
            if (clock_u && !prev) begin
                rises++;
                if (first == 0) first = cycles;
            end
            prev = clock_u;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, got 0 expected 1 entry");
            return;
        end
        e = sb.pop_front();
        check("lock_latency", 64'(cycles), 64'(RESOL));
        check("out", 64'(out), 64'(e.exp_out));
        check("sat", 64'(sat), 64'(e.exp_sat));
        check("rises", 64'(rises), 64'(e.exp_out));
        check("toggles", 64'(toggles), 64'(2 * e.exp_out));
        check("first_rise", 64'(first), 64'(e.exp_first));
        check("clock_u_done", 64'(clock_u), 64'd0);
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            in = $urandom;
            if (!(lock === 1'b1 && clock_u === 1'b0 && out === e.exp_out && sat === e.exp_sat))
                hold_ok = 1'b0;
        end
        check("done_hold", 64'(hold_ok), 64'd1);
        enable = 1'b0;
        tick();
        check("idle_lock", 64'(lock), 64'd0);
        check("idle_out", 64'(out), 64'(e.exp_out));
        check("idle_sat", 64'(sat), 64'(e.exp_sat));
    endtask

    initial begin
        vec_t v250;
        logic idle_ok;

        vecs[0] = '{32'd250,        32'd250, 1'b0, 2};
        vecs[1] = '{32'd1,          32'd1,   1'b0, 500};
        vecs[2] = '{32'd600,        32'd500, 1'b1, 1};
        vecs[3] = '{32'd0,          32'd0,   1'b0, 0};
        vecs[4] = '{32'd500,        32'd500, 1'b0, 1};
        vecs[5] = '{32'd501,        32'd500, 1'b1, 1};
        vecs[6] = '{32'd3,          32'd3,   1'b0, 167};
        vecs[7] = '{32'hFFFF_FFFF,  32'd500, 1'b1, 1};
        v250    = vecs[0];

        reset_n = 1'b0;
        enable  = 1'b0;
        in      = '0;
        tick();
        tick();
        check("rst_clock_u", 64'(clock_u), 64'd0);
        check("rst_lock", 64'(lock), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) begin
            run_window(vecs[k]);
        end

        // Abort after 300 RUN cycles: 75 rising edges already emitted.
        in     = 32'd250;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) tick();
        enable = 1'b0;
        tick();
        check("abort_clock_u", 64'(clock_u), 64'd0);
        check("abort_lock", 64'(lock), 64'd0);
        check("abort_out", 64'(out), 64'd75);
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(clock_u === 1'b0 && lock === 1'b0 && out === 32'd75)) idle_ok = 1'b0;
        end
        check("abort_idle", 64'(idle_ok), 64'd1);
        run_window(v250);

        // Reset in the middle of RUN with enable still high.
        in     = 32'd250;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 399; i++) tick();
        check("pre_reset_out", 64'(out), 64'd100);
        reset_n = 1'b0;
        tick();
        check("mid_rst_clock_u", 64'(clock_u), 64'd0);
        check("mid_rst_lock", 64'(lock), 64'd0);
        check("mid_rst_sat", 64'(sat), 64'd0);
        check("mid_rst_out", 64'(out), 64'd0);
        idle_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(clock_u === 1'b0 && lock === 1'b0 && out === 32'd0)) idle_ok = 1'b0;
        end
        check("rst_priority", 64'(idle_ok), 64'd1);
        enable  = 1'b0;
        reset_n = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(clock_u === 1'b0 && lock === 1'b0 && out === 32'd0)) idle_ok = 1'b0;
        end
        check("post_rst_idle", 64'(idle_ok), 64'd1);
        run_window(v250);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/generador_frec.md
GENERADOR_FREC -- requirements
Module: generador_frec

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 32, giving the width of the requested edge count.
REQ-002 The module SHALL have parameter RESOL, default 1000, giving the window length in clock cycles; the legal range is 2 to 2^30.
REQ-003 Port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 Port enable, input, 1: level request; high starts and holds a window, low aborts or rearms.
REQ-006 Port in, input, IN_WIDTH: N, the number of rising edges to generate in one window.
REQ-007 Port clock_u, output, 1: the generated signal, registered.
REQ-008 Port lock, output, 1: high when the window is complete.
REQ-009 Port sat, output, 1: high when the latched N was clamped.
REQ-010 Port out, output, IN_WIDTH: count of rising edges emitted on clock_u in the current or last window.

Function
REQ-011 The module SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE, when enable=1 at a clock edge, the module SHALL on that edge:
- set state to RUN;
- latch n_lat = min(in, floor(RESOL/2));
- set sat = (in > floor(RESOL/2));
- clear the accumulator acc, the cycle counter cnt and out;
- set lock to 0.
REQ-013 On each RUN edge the module SHALL compute sum = acc + 2*n_lat.
- If sum >= RESOL: acc <= sum - RESOL and clock_u toggles.
- Otherwise: acc <= sum.
- In both cases cnt increments.
REQ-014 Each 0->1 toggle of clock_u in RUN SHALL increment out in the same edge.
REQ-015 On the RUN edge where cnt == RESOL-1, the state SHALL become DONE and lock SHALL be 1 from the following cycle.
REQ-016 A completed window SHALL contain exactly n_lat rising and n_lat falling clock_u transitions, so clock_u is 0 on entering DONE.
REQ-017 Toggles SHALL be evenly spread (phase-accumulator distribution); with n_lat = RESOL/2, clock_u toggles every cycle (clock/2).
REQ-018 In DONE the module SHALL hold clock_u=0, lock=1, and out and sat stable.
REQ-019 In DONE, when enable=0, the state SHALL become IDLE and lock SHALL clear on the same edge; out and sat are retained.
REQ-020 If enable=0 on any RUN edge, the module SHALL abort:
- state becomes IDLE;
- clock_u becomes 0;
- lock stays 0;
- out keeps its partial count.
REQ-021 n_lat SHALL be immune to changes of in during RUN and DONE; in is sampled only on the IDLE->RUN edge.
REQ-022 acc and cnt SHALL be 32-bit unsigned.
- acc < RESOL always holds.
- sum < 2*RESOL, so no overflow.
REQ-023 When n_lat = 0, clock_u SHALL stay 0 for the whole window and lock SHALL still assert after RESOL cycles.

Reset
REQ-024 When reset_n=0 at a clock edge, the module SHALL return to IDLE and clear clock_u, lock, sat, out, acc, cnt and n_lat to 0.
- Reset has priority over enable.
- Reset mid-RUN behaves identically.
REQ-025 After reset_n returns to 1, the module SHALL need a fresh enable=1 sample in IDLE to start a window.

Structure
REQ-026 A shared package frec_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the 32-bit accumulator/counter width constant.
REQ-027 The phase accumulator (acc, sum, compare, toggle strobe) SHALL be a sub-module acumulador_fase with inputs clock, reset_n, clear, step[31:0], and RESOL as a parameter.
REQ-028 The FSM, latch, clamp and edge counter SHALL remain in generador_frec.

Verification (RESOL=1000)
REQ-029 The bench SHALL cover these scenarios:
- V1: N=250, enable held high -> 250 rising edges with clock_u period 4 cycles; lock=1 after 1000 RUN cycles; out=250, sat=0.
- V2: N=1 -> single high pulse, rising at RUN cycle 500 (cnt=499 edge) and falling at cycle 1000; out=1; lock=1.
- V3: N=600 -> n_lat=500, sat=1; clock_u toggles every cycle; out=500.
- V4: N=0 -> clock_u constant 0; lock=1 after 1000 cycles; out=0.
- V5: N=250, enable dropped at RUN cycle 300 -> next cycle clock_u=0, state IDLE, lock=0, out=75; re-enable starts a full fresh window.
- V6: reset_n=0 during RUN cycle 400 with enable high -> next cycle all outputs 0; the window restarts only on the first enable=1 sample after reset_n=1.
